// File: rtl/pxs_score_controller.sv
// pxs_score_controller: match sequencer for the score overlays.
// Runs IDLE/ARM/HOLD/PLAY/GAMEOVER and keeps two BCD scores. Every
// registered output moves only on the end-of-frame tick, so overlays never
// change mid-frame. The pixel stream is only tapped for its XC/YC fields.
// Optional build macro SCORE_BLINK_EN: blink score_visible during game over.
module pxs_score_controller #(
    parameter logic [7:0] WIN_SCORE    = 8'h09,
    parameter int         HOLD_FRAMES  = 60,
    parameter int         BLINK_FRAMES = 16,
    parameter int         VISIBLECOLS  = 640,
    parameter int         VISIBLEROWS  = 480
) (
    input  logic        px_clk,
    input  logic        reset,
    input  logic [25:0] RGBStr_i,
    input  logic        start,
    input  logic        point_p1,
    input  logic        point_p2,
    output logic [7:0]  score1,
    output logic [7:0]  score2,
    output logic        play_en,
    output logic        serve,
    output logic        game_over,
    output logic        winner,
    output logic        score_visible
);

    // Stream layout: RGB[25:23], XC[22:13], YC[12:3], HS[2], VS[1], Active[0]
    localparam int XC_LSB = 13;
    localparam int YC_LSB = 3;
    localparam int CW     = 10;
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_HOLD,
        S_PLAY,
        S_OVER
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  score1_q, score1_d;
    logic [7:0]  score2_q, score2_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pend1_q, pend1_d;
    logic        pend2_q, pend2_d;
    logic        play_en_q, play_en_d;
    logic        serve_q, serve_d;
    logic        game_over_q, game_over_d;
    logic        winner_q, winner_d;
    logic        eof_d_q;

    logic [CW-1:0] xc, yc;
    logic          eof, tick;
    logic [7:0]    inc_v;
    logic          unused_px;

    // BCD increment of a {tens, ones} pair, sticking at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign xc        = RGBStr_i[XC_LSB +: CW];
    assign yc        = RGBStr_i[YC_LSB +: CW];
    assign unused_px = ^{RGBStr_i[25:23], RGBStr_i[2:0]};
    assign eof       = (xc == CW'(VISIBLECOLS - 1)) && (yc == CW'(VISIBLEROWS - 1));
    // Rising edge only: a repeated end-of-frame pixel still gives one tick.
    assign tick      = eof && !eof_d_q;
    // Only one score increments per tick; pend1 selects which.
    assign inc_v     = bcd_inc(pend1_q ? score1_q : score2_q);

    // Next-state and registered-output logic of the match FSM.
    always_comb begin
        state_d     = state_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        cnt_d       = cnt_q;
        pend1_d     = pend1_q;
        pend2_d     = pend2_q;
        play_en_d   = play_en_q;
        serve_d     = 1'b0;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        unique case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = S_ARM;
            end
            S_ARM: begin
                if (tick) begin
                    score1_d    = 8'h00;
                    score2_d    = 8'h00;
                    game_over_d = 1'b0;
                    cnt_d       = HOLD_LOAD;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (tick) begin
                    cnt_d = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        state_d   = S_PLAY;
                        play_en_d = 1'b1;
                        serve_d   = 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (tick && (pend1_q || pend2_q)) begin
                    if (pend1_q)
                        score1_d = inc_v;
                    else
                        score2_d = inc_v;
                    pend1_d   = 1'b0;
                    pend2_d   = 1'b0;
                    play_en_d = 1'b0;
                    if (inc_v == WIN_SCORE) begin
                        state_d     = S_OVER;
                        game_over_d = 1'b1;
                        winner_d    = pend2_q;
                    end else begin
                        cnt_d   = HOLD_LOAD;
                        state_d = S_HOLD;
                    end
                end else if (!pend1_q && !pend2_q) begin
                    // First lone event of the rally wins; a simultaneous pair is a tie.
                    pend1_d = point_p1 && !point_p2;
                    pend2_d = point_p2 && !point_p1;
                end
            end
            S_OVER: begin
                if (start)
                    state_d = S_ARM;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            score1_q    <= 8'h00;
            score2_q    <= 8'h00;
            cnt_q       <= 8'd0;
            pend1_q     <= 1'b0;
            pend2_q     <= 1'b0;
            play_en_q   <= 1'b0;
            serve_q     <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            eof_d_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            cnt_q       <= cnt_d;
            pend1_q     <= pend1_d;
            pend2_q     <= pend2_d;
            play_en_q   <= play_en_d;
            serve_q     <= serve_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            eof_d_q     <= eof;
        end
    end

`ifdef SCORE_BLINK_EN
    localparam logic [7:0] BLINK_LOAD = 8'(BLINK_FRAMES);

    logic       vis_q, vis_d;
    logic [7:0] blink_q, blink_d;

    // Blink timer: toggles visibility every BLINK_FRAMES ticks in game over.
    always_comb begin
        vis_d   = vis_q;
        blink_d = blink_q;
        if (state_q == S_OVER && !start) begin
            if (tick) begin
                if (blink_q >= BLINK_LOAD - 8'd1) begin
                    blink_d = 8'd0;
                    vis_d   = !vis_q;
                end else begin
                    blink_d = blink_q + 8'd1;
                end
            end
        end else begin
            // Outside game over (and on leaving it) the scores are always shown.
            vis_d   = 1'b1;
            blink_d = 8'd0;
        end
    end

    // Blink registers.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            vis_q   <= 1'b1;
            blink_q <= 8'd0;
        end else begin
            vis_q   <= vis_d;
            blink_q <= blink_d;
        end
    end

    assign score_visible = vis_q;
`else
    logic unused_blink;
    assign unused_blink  = ^8'(BLINK_FRAMES);
    assign score_visible = 1'b1;
`endif

    assign score1    = score1_q;
    assign score2    = score2_q;
    assign play_en   = play_en_q;
    assign serve     = serve_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: doc/pxs_score_controller.md
Name: pxs_score_controller

Overview:
Game score sequencer that drives the score inputs of the score-overlay blocks in the pixel-stream pipeline.
- Runs a match FSM: idle, arm, serve hold, play, game over.
- Accepts one-cycle point events from game logic.
- Keeps two 2-digit BCD scores.
- Scores and status outputs change only at the end-of-frame pixel, so overlays never tear mid-frame.
- Taps the pixel stream (RGBStr, 26 bits, Pxs.vh field layout) only to detect frame end; it does not drive a stream.

Parameters:
- WIN_SCORE, 8'h09: BCD score that ends the match.
- HOLD_FRAMES, 60: frames of serve delay after arm and after each point; range 1..255.
- BLINK_FRAMES, 16: half-period in frames of the game-over blink (optional feature only).
- VISIBLECOLS, 640: visible columns; end of frame is XC == VISIBLECOLS-1.
- VISIBLEROWS, 480: visible rows; end of frame is YC == VISIBLEROWS-1.

Ports:
- px_clk, in, 1: pixel clock; the only clock.
- reset, in, 1: synchronous, active-high.
- RGBStr_i, in, 26: pixel stream; only the `XC and `YC fields are used.
- start, in, 1: level; starts or restarts a match.
- point_p1, in, 1: one-cycle pulse; player 1 scored.
- point_p2, in, 1: one-cycle pulse; player 2 scored.
- score1, out, 8: BCD score of player 1, {tens, ones}.
- score2, out, 8: BCD score of player 2.
- play_en, out, 1: high while in PLAY; game logic moves the ball only when high.
- serve, out, 1: one-cycle pulse on entry to PLAY.
- game_over, out, 1: high in GAMEOVER.
- winner, out, 1: 0 = player 1, 1 = player 2; valid while game_over.
- score_visible, out, 1: overlay enable.

Behaviour:
- Reset, synchronous: state IDLE, score1 = score2 = 8'h00, play_en = serve = game_over = winner = 0, score_visible = 1, pending flags and frame counter cleared.
  - Reset wins over every other input in the same cycle.
  - Reset in any state, including mid-HOLD with points pending, gives the same result.
- Frame tick:
  - eof = (XC == VISIBLECOLS-1) && (YC == VISIBLEROWS-1) on RGBStr_i.
  - tick = eof && !eof_d, with eof_d registered. One tick per frame even if the pixel repeats.
  - Every registered output updates in the cycle after the tick cycle (latency 1).
- States:
  - IDLE: start=1 -> ARM.
  - GAMEOVER: start=1 -> ARM.
  - ARM: at tick, score1 = score2 = 0, game_over = 0, frame counter loaded with HOLD_FRAMES -> HOLD.
  - HOLD: each tick decrements the counter. The tick that brings it to 0 -> PLAY, and serve pulses high for exactly one cycle coinciding with play_en rising.
  - PLAY: point events are latched into pend1/pend2 (see Point rules). At the first tick with a pending flag set:
    - The flagged score increments in BCD.
    - If the new value == WIN_SCORE -> GAMEOVER, winner set (0 for player 1, 1 for player 2).
    - Otherwise counter = HOLD_FRAMES -> HOLD.
    - Pending flags clear.
    - A tick with nothing pending: stay in PLAY.
  - GAMEOVER: scores frozen, game_over = 1.
- start has no effect in ARM, HOLD or PLAY.
- Point rules:
  - Only the first event of a rally counts. Once pend1 or pend2 is set, further events are ignored until the tick.
  - point_p1 and point_p2 in the same cycle with nothing pending: both ignored, score unchanged (tie).
  - Events outside PLAY are ignored.
  - An event in the same cycle as a tick in PLAY is latched and applied at the next tick.
- BCD arithmetic:
  - ones 9 -> 0 with tens +1.
  - 8'h99 saturates (unreachable when WIN_SCORE <= 8'h99).
  - The winning comparison is an exact 8-bit BCD compare.

Optional Feature:
Macro SCORE_BLINK_EN.
- Defined:
  - In GAMEOVER, score_visible toggles every BLINK_FRAMES ticks, starting at 1 on entry.
  - It is forced to 1 when leaving GAMEOVER and on reset.
  - Uses an extra blink counter.
- Undefined: score_visible is constant 1 and no blink counter is built.

Test Plan:
1. Reset then idle frames (frame tick = RGBStr_i sweeping a 640x480 raster) -> score1 = score2 = 8'h00, play_en = 0, game_over = 0, serve never pulses.
2. HOLD_FRAMES=2: start -> ARM; next tick -> HOLD; 2 ticks later -> play_en = 1 and one serve pulse, in the cycle after the 3rd tick.
3. In PLAY: point_p1 mid-frame, then point_p2 in the same frame -> at the next tick score1 = 8'h01, score2 = 8'h00, play_en = 0, HOLD entered. Separately, simultaneous point_p1 + point_p2 -> no score change, stays in PLAY.
4. WIN_SCORE=8'h15, player 1 wins ten rallies -> score1 steps 8'h09 -> 8'h10 (BCD carry); reaching 8'h15 -> game_over = 1, winner = 0; later point_p2 ignored; start -> ARM, scores 8'h00 at the next tick.
5. Reset asserted mid-HOLD with score2 = 8'h03 -> next cycle all outputs at reset values, state IDLE.
6. SCORE_BLINK_EN defined, BLINK_FRAMES=2: in GAMEOVER, score_visible follows 1,1,0,0,1... per tick; with the macro undefined it stays 1.
